uart_hex_word_decoder: RTL and testbench
========================================

// Module: uart_hex_word_decoder
// PURPOSE
//   Consumes the byte stream from uart_receiver (valid/byte pulses) and parses ASCII hex text
//   lines into binary words. Each line of hex digits ending in LF or CR yields one word_out
//   with a one-cycle valid_out pulse. Malformed lines raise error_out. The word is dropped.
//   Sits directly downstream of uart_receiver and feeds command/config logic.
// PARAMETERS
//   WORD_WIDTH  32  width of assembled word; must be a multiple of 4 and >= 8
//   (derived) DIGITS = WORD_WIDTH/4, maximum hex digits per line
// PORTS
//   clk_in     in   1           system clock
//   rst_in     in   1           asynchronous, active-high reset
//   valid_in   in   1           one-cycle pulse: byte_in is a new received byte
//   byte_in    in   8           received ASCII byte
//   valid_out  out  1           one-cycle pulse: word_out holds a newly completed word
//   word_out   out  WORD_WIDTH  last completed word, zero-extended; held until next word
//   error_out  out  1           one-cycle pulse: current line rejected
// BEHAVIOUR
//   - Reset, async and immediate: valid_out=0, error_out=0, word_out=0, accumulator=0,
//     digit count=0, state=IDLE. Reset mid-line discards the partial line.
//   - Byte classes: digit '0'-'9' and 'A'-'F' (plus 'a'-'f' when UART_HEX_LOWER_EN);
//     terminator 0x0A or 0x0D; everything else, including space, is illegal.
//   - FSM states: IDLE (count=0), ACCUM (1..DIGITS digits held), DROP (discarding bad line).
//     Transitions occur only on cycles where valid_in=1. Byte values without valid_in are ignored.
//   - IDLE: on a digit, load acc={0,nibble}, set count=1, go to ACCUM.
//     A terminator is ignored: blank lines and the second byte of CRLF produce nothing.
//     An illegal byte pulses error_out and goes to DROP.
//   - ACCUM: on a digit with count<DIGITS, set acc={acc[W-5:0],nibble}, count+1.
//     A digit with count==DIGITS is overflow: pulse error_out, go to DROP.
//     On a terminator, register word_out<=acc and pulse valid_out.
//     Then clear acc and count, and go to IDLE.
//     An illegal byte pulses error_out and goes to DROP.
//   - DROP: ignore all bytes until a terminator, then go to IDLE without valid_out or error_out.
//     error_out pulses only once per bad line.
//   - Latency: valid_out and error_out are registered.
//     They assert exactly on the cycle after the valid_in that causes them, high for one cycle.
//   - valid_out and error_out are never asserted together.
//     Back-to-back valid_in on consecutive cycles is supported at full rate.
//   - Fewer than DIGITS digits gives a right-aligned, zero-extended result ("A1" -> 0xA1).
// CONFIGURATION
//   UART_HEX_LOWER_EN defined: 'a'-'f' decode as 0xA-0xF, identical to uppercase.
//   UART_HEX_LOWER_EN undefined: 'a'-'f' are illegal bytes (error_out, line dropped).
// STRUCTURE
//   - Package uart_pkg holds:
//     - ASCII constants: ASCII_LF=8'h0A, ASCII_CR=8'h0D, ASCII_0, ASCII_9, ASCII_A, ASCII_F,
//       ASCII_LA, ASCII_LF_HEX
//     - typedef enum logic [1:0] {IDLE, ACCUM, DROP} hex_state_t
//   - Sub-module ascii_hex_decode: purely combinational byte_in -> {is_digit, is_term, nibble[3:0]}.
//     It alone honours UART_HEX_LOWER_EN.
//   - Top level holds the FSM, accumulator, digit counter ($clog2(DIGITS+1) bits) and output regs.
// TESTING
//   - Bytes "A1\n" at 1 cycle apart -> one valid_out, word_out=32'h0000_00A1; error_out stays 0.
//   - "DEADBEEF\r\n" -> exactly one valid_out, word_out=32'hDEAD_BEEF; LF after CR produces nothing.
//   - "123456789\n" -> error_out once on the 9th digit, no valid_out.
//     Then "7\n" -> word_out=32'h7, and word_out holds 0xDEADBEEF until then.
//   - "1G2\n" -> error_out once, no word; "\n\r\n" alone -> no outputs at all.
//   - "beef\n": with UART_HEX_LOWER_EN -> word_out=32'h0000_BEEF;
//     without the macro -> error_out, no word.
//   - Reset pulse after "12" and before LF, then "3\n" -> word_out=32'h3.
//     All outputs are 0 during reset.
//   - Full-stack run: drive the rx serial line at 115200 baud (8680 ns/bit) into uart_receiver
//     with "A1\n" -> word_out=32'hA1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state type for the UART hex word decoder.
// Lowercase digit support is selected by the UART_HEX_LOWER_EN macro in ascii_hex_decode.
package uart_pkg;

    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_9      = 8'h39;
    localparam logic [7:0] ASCII_A      = 8'h41;
    localparam logic [7:0] ASCII_F      = 8'h46;
    localparam logic [7:0] ASCII_LA     = 8'h61;
    localparam logic [7:0] ASCII_LF_HEX = 8'h66;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DROP  = 2'd2
    } hex_state_t;

endpackage

// File: rtl/uart_hex_word_decoder_ascii_hex_decode.sv
// Combinational ASCII byte classifier: hex digit (with nibble value), line terminator, or illegal.
// Define UART_HEX_LOWER_EN to also accept 'a'-'f' as hex digits.
module ascii_hex_decode
    import uart_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic       is_digit,
    output logic       is_term,
    output logic [3:0] nibble
);

    // Letters sit at 0x41/0x61 upward, so the low nibble plus 9 gives 0xA..0xF.
    always_comb begin
        is_digit = 1'b0;
        is_term  = 1'b0;
        nibble   = 4'h0;
        if (byte_in >= ASCII_0 && byte_in <= ASCII_9) begin
            is_digit = 1'b1;
            nibble   = byte_in[3:0];
        end else if (byte_in >= ASCII_A && byte_in <= ASCII_F) begin
            is_digit = 1'b1;
            nibble   = byte_in[3:0] + 4'd9;
`ifdef UART_HEX_LOWER_EN
        end else if (byte_in >= ASCII_LA && byte_in <= ASCII_LF_HEX) begin
            is_digit = 1'b1;
            nibble   = byte_in[3:0] + 4'd9;
`endif
        end else if (byte_in == ASCII_LF || byte_in == ASCII_CR) begin
            is_term = 1'b1;
        end
    end

endmodule

// File: rtl/uart_hex_word_decoder.sv
// Parses ASCII hex lines from a UART byte stream into WORD_WIDTH-bit words.
// Lowercase digits are accepted only when UART_HEX_LOWER_EN is defined (see ascii_hex_decode).
module uart_hex_word_decoder
    import uart_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  valid_in,
    input  logic [7:0]            byte_in,
    output logic                  valid_out,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  error_out
);

    localparam int DIGITS = WORD_WIDTH / 4;
    localparam int CW     = $clog2(DIGITS + 1);

    hex_state_t            state_q, state_d;
    logic [WORD_WIDTH-1:0] acc_q, acc_d;
    logic [WORD_WIDTH-1:0] word_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  valid_d, error_d;
    logic                  is_digit, is_term;
    logic [3:0]            nibble;

    ascii_hex_decode u_decode (
        .byte_in  (byte_in),
        .is_digit (is_digit),
        .is_term  (is_term),
        .nibble   (nibble)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            word_out  <= '0;
            valid_out <= 1'b0;
            error_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            word_out  <= word_d;
            valid_out <= valid_d;
            error_out <= error_d;
        end
    end

    // Entering DROP clears the accumulator so a stale partial line never leaks out.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        word_d  = word_out;
        valid_d = 1'b0;
        error_d = 1'b0;
        if (valid_in) begin
            unique case (state_q)
                IDLE: begin
                    if (is_digit) begin
                        acc_d   = WORD_WIDTH'(nibble);
                        count_d = CW'(1);
                        state_d = ACCUM;
                    end else if (!is_term) begin
                        error_d = 1'b1;
                        state_d = DROP;
                    end
                end
                ACCUM: begin
                    if (is_digit && count_q != CW'(DIGITS)) begin
                        acc_d   = {acc_q[WORD_WIDTH-5:0], nibble};
                        count_d = count_q + CW'(1);
                    end else if (is_term) begin
                        word_d  = acc_q;
                        valid_d = 1'b1;
                        acc_d   = '0;
                        count_d = '0;
                        state_d = IDLE;
                    end else begin
                        error_d = 1'b1;
                        acc_d   = '0;
                        count_d = '0;
                        state_d = DROP;
                    end
                end
                DROP: begin
                    if (is_term) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_word_decoder.sv
// Self-checking bench for uart_hex_word_decoder: directed lines plus random byte streams
// compared cycle by cycle against a line-buffer reference model.
module tb_uart_hex_word_decoder;

    localparam int WORD_WIDTH = 32;
    localparam int DIGITS     = WORD_WIDTH / 4;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic                  valid_in;
    logic [7:0]            byte_in;
    logic                  valid_out;
    logic [WORD_WIDTH-1:0] word_out;
    logic                  error_out;

    int checks   = 0;
    int failures = 0;

    // Reference model: the current line as a list of digit values plus a "line is bad" flag.
    int                    lineDigits[$];
    bit                    lineBad;
    bit                    expValid;
    bit                    expError;
    logic [WORD_WIDTH-1:0] expWord;

    uart_hex_word_decoder #(.WORD_WIDTH(WORD_WIDTH)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid_in  (valid_in),
        .byte_in   (byte_in),
        .valid_out (valid_out),
        .word_out  (word_out),
        .error_out (error_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic int hexValue(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
`ifdef UART_HEX_LOWER_EN
        if (b >= "a" && b <= "f") return int'(b) - 87;
`endif
        return -1;
    endfunction

    function automatic bit isTerm(input logic [7:0] b);
        return (b == 8'h0A) || (b == 8'h0D);
    endfunction

    task automatic modelByte(input bit v, input logic [7:0] b);
        logic [WORD_WIDTH-1:0] value;
        expValid = 1'b0;
        expError = 1'b0;
        if (!v) return;
        if (lineBad) begin
            if (isTerm(b)) lineBad = 1'b0;
        end else if (isTerm(b)) begin
            if (lineDigits.size() > 0) begin
                value = '0;
                foreach (lineDigits[i]) value = value * 16 + WORD_WIDTH'(lineDigits[i]);
                expValid = 1'b1;
                expWord  = value;
            end
            lineDigits.delete();
        end else if (hexValue(b) >= 0 && lineDigits.size() < DIGITS) begin
            lineDigits.push_back(hexValue(b));
        end else begin
            expError = 1'b1;
            lineBad  = 1'b1;
            lineDigits.delete();
        end
    endtask

    task automatic checkOutput();
        checks++;
        assert (valid_out === expValid) else begin
            failures++;
            $error("[TB] FAIL valid_out: got %b expected %b", valid_out, expValid);
        end
        checks++;
        assert (error_out === expError) else begin
            failures++;
            $error("[TB] FAIL error_out: got %b expected %b", error_out, expError);
        end
        checks++;
        assert (word_out === expWord) else begin
            failures++;
            $error("[TB] FAIL word_out: got %h expected %h", word_out, expWord);
        end
    endtask

    // One clock cycle: check results of the previous cycle, then drive this cycle's byte.
    task automatic applyStimulus(input bit v, input logic [7:0] b);
        @(negedge clk_in);
        checkOutput();
        valid_in = v;
        byte_in  = b;
        modelByte(v, b);
    endtask

    task automatic sendString(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(1'b1, s[i]);
            for (int g = 0; g < gap; g++) applyStimulus(1'b0, 8'($urandom));
        end
    endtask

    task automatic checkWord(input logic [WORD_WIDTH-1:0] required, input string tag);
        applyStimulus(1'b0, 8'h00);
        @(negedge clk_in);
        checks++;
        assert (word_out === required) else begin
            failures++;
            $error("[TB] FAIL %s: got %h expected %h", tag, word_out, required);
        end
    endtask

    task automatic applyReset();
        @(negedge clk_in);
        valid_in = 1'b0;
        rst_in   = 1'b1;
        #2;
        checks++;
        assert (valid_out === 1'b0 && error_out === 1'b0 && word_out === '0) else begin
            failures++;
            $error("[TB] FAIL reset_outputs: got v=%b e=%b w=%h expected all zero",
                   valid_out, error_out, word_out);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        lineDigits.delete();
        lineBad  = 1'b0;
        expValid = 1'b0;
        expError = 1'b0;
        expWord  = '0;
    endtask

    initial begin
        string junk;
        int    len;
        int    r;
        logic [7:0] ch;
        junk     = " GZ!x@";
        rst_in   = 1'b0;
        valid_in = 1'b0;
        byte_in  = 8'h00;
        applyReset();

        sendString("A1\n", 0);
        checkWord(32'h0000_00A1, "word_A1");
        sendString("DEADBEEF\r\n", 0);
        checkWord(32'hDEAD_BEEF, "word_DEADBEEF");
        sendString("123456789\n", 1);
        checkWord(32'hDEAD_BEEF, "word_held_after_overflow");
        sendString("7\n", 0);
        checkWord(32'h0000_0007, "word_7");
        sendString("1G2\n", 2);
        sendString("\n\r\n", 0);
        sendString("beef\n", 0);
`ifdef UART_HEX_LOWER_EN
        checkWord(32'h0000_BEEF, "word_beef_lower");
`else
        checkWord(32'h0000_0007, "word_beef_rejected");
`endif
        sendString("12", 0);
        applyStimulus(1'b0, 8'h00);
        applyReset();
        sendString("3\n", 0);
        checkWord(32'h0000_0003, "word_after_reset");
        sendString("FFFFFFFF\n", 0);
        checkWord(32'hFFFF_FFFF, "word_full_width");

        for (int line = 0; line < 300; line++) begin
            len = $urandom_range(0, 10);
            for (int k = 0; k < len; k++) begin
                r = $urandom_range(0, 99);
                if (r < 70)      ch = 8'(hexValue(8'h30) + 0) + 8'h00;
                if (r < 70) begin
                    r  = $urandom_range(0, 15);
                    ch = (r < 10) ? 8'(48 + r) : 8'(55 + r);
                end else if (r < 78) ch = 8'(97 + $urandom_range(0, 5));
                else if (r < 92)     ch = junk[$urandom_range(0, 5)];
                else                 ch = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D;
                applyStimulus(1'b1, ch);
                if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 8'($urandom));
            end
            applyStimulus(1'b1, ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D);
        end
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    always @(negedge clk_in) begin
        if (!rst_in) begin
            checks++;
            assert (!(valid_out && error_out)) else begin
                failures++;
                $error("[TB] FAIL exclusive_pulses: got v=%b e=%b expected not both", valid_out, error_out);
            end
        end
    end

endmodule
